// File: rtl/kbd_pkg.sv
// Shared scancodes, decoder state encoding and key-index mapping for keyboard_ctl.
package kbd_pkg;

    // Receiver frame geometry: start + 8 data + parity + stop.
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_CNT_W  = 4;

    // Prefix and control scancodes.
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA;

    // Non-extended (fire player) scancodes.
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_D = 8'h23;

    // Extended (water player) scancodes, valid only after an E0 prefix.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Bit positions in the packed key vector.
    localparam int unsigned NUM_KEYS = 8;
    localparam logic [2:0] KEY_W     = 3'd0;
    localparam logic [2:0] KEY_A     = 3'd1;
    localparam logic [2:0] KEY_S     = 3'd2;
    localparam logic [2:0] KEY_D     = 3'd3;
    localparam logic [2:0] KEY_UP    = 3'd4;
    localparam logic [2:0] KEY_LEFT  = 3'd5;
    localparam logic [2:0] KEY_DOWN  = 3'd6;
    localparam logic [2:0] KEY_RIGHT = 3'd7;

    // Decoder state: which prefixes have been seen for the byte in flight.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    // Lookup result: whether the code is one of ours, and which key bit it drives.
    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_map_t;

    // Map a scancode to a key bit; the extended and non-extended tables are disjoint.
    function automatic key_map_t kbd_map(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = '0;
        if (ext) begin
            case (code)
                SC_UP:    begin m.hit = 1'b1; m.idx = KEY_UP;    end
                SC_LEFT:  begin m.hit = 1'b1; m.idx = KEY_LEFT;  end
                SC_DOWN:  begin m.hit = 1'b1; m.idx = KEY_DOWN;  end
                SC_RIGHT: begin m.hit = 1'b1; m.idx = KEY_RIGHT; end
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_W:    begin m.hit = 1'b1; m.idx = KEY_W; end
                SC_A:    begin m.hit = 1'b1; m.idx = KEY_A; end
                SC_S:    begin m.hit = 1'b1; m.idx = KEY_S; end
                SC_D:    begin m.hit = 1'b1; m.idx = KEY_D; end
                default: m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, shifts in 11-bit frames on
// falling ps2_clk edges, checks start/parity/stop and aborts stalled frames.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         raw keyboard clock (asynchronous)
//   ps2_data        raw keyboard data (asynchronous)
//   rx_byte[7:0]    last accepted data byte (held until the next one)
//   rx_valid        one-cycle pulse, rx_byte is new
//   rx_err          one-cycle pulse, frame rejected (start, parity or stop)
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    logic                 clk_s1_q, clk_s1_d;
    logic                 clk_s2_q, clk_s2_d;
    logic                 clk_prev_q, clk_prev_d;
    logic                 dat_s1_q, dat_s1_d;
    logic                 dat_s2_q, dat_s2_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [9:0]           shift_q, shift_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [7:0]           byte_q, byte_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    logic                 fall;
    logic [10:0]          frame;
    logic                 frame_ok;

    // Next-state logic for synchronizers, bit counter, shifter and frame timeout.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = '0;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        fall = clk_prev_q & ~clk_s2_q;
        // The stop bit is still on the data line when the last edge arrives.
        frame    = {dat_s2_q, shift_q};
        frame_ok = ~frame[0] & (^frame[9:1]) & frame[10];

        if (fall) begin
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                shift_d   = '0;
                if (frame_ok) begin
                    valid_d = 1'b1;
                    byte_d  = frame[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                bit_cnt_d = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
                shift_d   = {dat_s2_q, shift_q[9:1]};
            end
        end else if (bit_cnt_q != '0) begin
            // Mid-frame stall: drop the partial frame without reporting it.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = '0;
                shift_d   = '0;
            end else begin
                tmo_d = TW'(tmo_q + TW'(1));
            end
        end
    end

    // State registers; synchronizers reset to the PS/2 idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;

endmodule

// File: rtl/keyboard_ctl.sv
// Two-player PS/2 keyboard controller: receives scancodes and tracks held
// levels of WASD (fire player) and the arrow keys (water player).
// Ports:
//   clk, rst                           system clock, synchronous active-high reset
//   ps2_clk, ps2_data                  raw PS/2 lines (asynchronous)
//   key_w, key_a, key_s, key_d         fire-player held levels
//   key_up, key_left, key_down,
//   key_right                          water-player held levels
//   rx_err                             one-cycle pulse on a rejected frame
module keyboard_ctl
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic key_w,
    output logic key_a,
    output logic key_s,
    output logic key_d,
    output logic key_up,
    output logic key_left,
    output logic key_down,
    output logic key_right,
    output logic rx_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err_w;

    dec_state_t            state_q, state_d;
    logic [NUM_KEYS-1:0]   keys_q, keys_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  ext;
    key_map_t              map;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err_w)
    );

    // Decoder next state: prefix tracking, key set/clear, prefix timeout.
    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        tmo_d   = '0;

        ext = (state_q == EXT) || (state_q == EXT_BRK);
        map = kbd_map(ext, rx_byte);

        if (rx_err_w) begin
            state_d = IDLE;
        end else if (rx_valid) begin
            case (rx_byte)
                SC_E0: state_d = EXT;
                SC_F0: begin
                    if (state_q == IDLE) begin
                        state_d = BRK;
                    end else if (state_q == EXT) begin
                        state_d = EXT_BRK;
                    end
                end
                default: begin
                    case (state_q)
                        IDLE: begin
                            if (rx_byte == SC_AA) begin
                                keys_d = '0;
                            end else if (map.hit) begin
                                keys_d[map.idx] = 1'b1;
                            end
                        end
                        EXT: begin
                            if (map.hit) begin
                                keys_d[map.idx] = 1'b1;
                            end
                        end
                        BRK, EXT_BRK: begin
                            if (map.hit) begin
                                keys_d[map.idx] = 1'b0;
                            end
                        end
                        default: keys_d = keys_q;
                    endcase
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE) begin
            // A prefix with no follow-up byte is abandoned.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
            end else begin
                tmo_d = TW'(tmo_q + TW'(1));
            end
        end
    end

    // Decoder state, key levels and prefix timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            keys_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            tmo_q   <= tmo_d;
        end
    end

    assign key_w     = keys_q[KEY_W];
    assign key_a     = keys_q[KEY_A];
    assign key_s     = keys_q[KEY_S];
    assign key_d     = keys_q[KEY_D];
    assign key_up    = keys_q[KEY_UP];
    assign key_left  = keys_q[KEY_LEFT];
    assign key_down  = keys_q[KEY_DOWN];
    assign key_right = keys_q[KEY_RIGHT];
    assign rx_err    = rx_err_w;

endmodule

// File: tb/tb_keyboard_ctl.sv
// Scoreboard bench for keyboard_ctl: frames are driven on the PS/2 lines,
// each frame that should change an output pushes its expected response, and a
// monitor compares whenever the key vector changes or rx_err pulses.
module tb_keyboard_ctl;
    import kbd_pkg::*;

    localparam int unsigned TMO  = 400;
    localparam int unsigned HALF = 8;
    localparam int unsigned GAP  = 30;
    localparam int          LAT_MAX = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic key_w, key_a, key_s, key_d;
    logic key_up, key_left, key_down, key_right;
    logic rx_err;

    keyboard_ctl #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_w     (key_w),
        .key_a     (key_a),
        .key_s     (key_s),
        .key_d     (key_d),
        .key_up    (key_up),
        .key_left  (key_left),
        .key_down  (key_down),
        .key_right (key_right),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       err;
        logic [7:0] keys;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   stop_cyc = 0;
    logic [7:0] prev_keys = 8'h00;

    logic [7:0] keys_v;
    assign keys_v = {key_right, key_down, key_left, key_up, key_d, key_s, key_a, key_w};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad);
        logic par;
        par = ~(^b) ^ bad;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            tick(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    // ev: frame must produce an observable event with the given keys/err.
    task automatic send(input logic [7:0] b, input logic bad, input logic ev,
                        input logic [7:0] k, input logic e);
        exp_t x;
        if (ev) begin
            x.err  = e;
            x.keys = k;
            exp_q.push_back(x);
        end
        send_bits(make_frame(b, bad), 11);
        ps2_data = 1'b1;
        tick(GAP);
    endtask

    // Monitor: any key change or rx_err pulse must match the next expectation.
    initial begin
        exp_t got;
        exp_t want;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_keys = 8'h00;
            end else begin
                if (keys_v !== prev_keys || rx_err === 1'b1) begin
                    got.err  = rx_err;
                    got.keys = keys_v;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event actual=%0h required=none (t=%0t)", got, $time);
                    end else begin
                        want = exp_q.pop_front();
                        check("event", 32'(got), 32'(want));
                        check("latency", 32'((cyc - stop_cyc) <= LAT_MAX), 32'(1));
                    end
                end
                prev_keys = keys_v;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(5);
        check("reset_outputs", 32'({rx_err, keys_v}), 32'(0));
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        tick(20);

        // W press and release
        send(8'h1D, 1'b0, 1'b1, 8'h01, 1'b0);
        send(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h1D, 1'b0, 1'b1, 8'h00, 1'b0);

        // Extended left press and release; A must not react
        send(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h6B, 1'b0, 1'b1, 8'h20, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h6B, 1'b0, 1'b1, 8'h00, 1'b0);

        // Bad parity on 1D, then a good 1C
        send(8'h1D, 1'b1, 1'b1, 8'h00, 1'b1);
        send(8'h1C, 1'b0, 1'b1, 8'h02, 1'b0);
        send(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h1C, 1'b0, 1'b1, 8'h00, 1'b0);

        // Stale E0 prefix times out; 1C is then a plain A
        send(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("ext_state", 32'(dut.state_q), 32'(EXT));
        tick(TMO + 10);
        check("prefix_timeout_idle", 32'(dut.state_q), 32'(IDLE));
        send(8'h1C, 1'b0, 1'b1, 8'h02, 1'b0);
        send(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h1C, 1'b0, 1'b1, 8'h00, 1'b0);

        // Unmapped make/break and E0 + non-extended code change nothing
        send(8'h15, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h15, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h1D, 1'b0, 1'b0, 8'h00, 1'b0);
        check("unmapped_state", 32'(dut.state_q), 32'(IDLE));

        // Multiple holds with typematic repeat, then AA clears all at once
        send(8'h1D, 1'b0, 1'b1, 8'h01, 1'b0);
        send(8'h1D, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h23, 1'b0, 1'b1, 8'h09, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h75, 1'b0, 1'b1, 8'h19, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h6B, 1'b0, 1'b1, 8'h39, 1'b0);
        send(8'h1C, 1'b0, 1'b1, 8'h3B, 1'b0);
        send(8'hAA, 1'b0, 1'b1, 8'h00, 1'b0);

        // Reset mid-frame, then a clean 23
        send_bits(make_frame(8'h23, 1'b0), 5);
        rst = 1'b1;
        tick(3);
        check("midreset_outputs", 32'({rx_err, keys_v}), 32'(0));
        check("midreset_bitcnt", 32'(dut.u_rx.bit_cnt_q), 32'(0));
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        send(8'h23, 1'b0, 1'b1, 8'h08, 1'b0);

        tick(50);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keyboard_ctl.md
KEYBOARD_CTL -- requirements
Module: keyboard_ctl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200000, idle-gap limit in clk cycles for frame and prefix abort.
REQ-002 clk  in  1  system clock; PS/2 lines are sampled in this domain.
REQ-003 rst  in  1  reset: rst, synchronous, active-high; clock clk.
REQ-004 ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-005 ps2_data  in  1  raw PS/2 data, asynchronous.
REQ-006 key_w, key_a, key_s, key_d  out  1 each  fire-player key held levels.
REQ-007 key_up, key_left, key_down, key_right  out  1 each  water-player arrow-key held levels.
REQ-008 rx_err  out  1  one-cycle pulse on a rejected frame (start, parity or stop error).

Function
REQ-009 Each of ps2_clk and ps2_data SHALL pass through a 2-flop synchronizer; a falling edge is ps2_clk_sync high in the previous cycle and low in the current cycle.
REQ-010 On each falling edge the receiver SHALL shift in ps2_data_sync as 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1); a bit counter counts 0..10.
REQ-011 After bit 10, the receiver SHALL output byte plus a 1-cycle valid on the next cycle if start==0, data+parity has odd ones count, and stop==1; otherwise it SHALL pulse rx_err instead, with no valid.
REQ-012 The bit counter SHALL return to 0 after bit 10 and whenever TIMEOUT_CYCLES cycles pass with no falling edge while mid-frame; the partial frame is discarded silently.
REQ-013 The decoder FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-014 On a valid byte: E0 from any state -> EXT; F0 from IDLE -> BRK, from EXT -> EXT_BRK, from BRK/EXT_BRK no change.
REQ-015 On any other byte: IDLE sets the non-extended key, EXT sets the extended key, BRK clears the non-extended key, EXT_BRK clears the extended key; the next state is always IDLE.
REQ-016 The non-extended map SHALL be 1D=W, 1C=A, 1B=S, 23=D; the extended map SHALL be 75=up, 6B=left, 72=down, 74=right; any unmapped code changes no output but still returns to IDLE.
REQ-017 Byte AA (keyboard self-test pass) in IDLE SHALL clear all eight key outputs.
REQ-018 Repeated make codes for an already-held key (typematic) SHALL leave outputs unchanged.
REQ-019 A key output SHALL change in the cycle after the receiver's valid pulse, i.e. 3 cycles after the synchronized falling edge sampling the stop bit.
REQ-020 When the FSM is not in IDLE and TIMEOUT_CYCLES cycles pass with no valid byte, the FSM SHALL return to IDLE with no output change.
REQ-021 An rx_err pulse SHALL force the FSM to IDLE and leave outputs unchanged.
REQ-022 Key outputs SHALL be registered and glitch-free; the key bits SHALL be independent, so simultaneous holds (e.g. W+D, A+left) are all reported.

Reset
REQ-023 While rst is high, all key outputs and rx_err SHALL be 0, the FSM SHALL be in IDLE, and the bit counter, shift register and both timeout counters SHALL be 0.
REQ-024 Synchronizer flops SHALL reset to 1, the PS/2 idle level, so no spurious edge is detected on reset release.
REQ-025 Asserting rst mid-frame SHALL discard the frame; reception resumes cleanly at the next start bit.

Structure
REQ-026 Scancode constants (E0, F0, AA, 1D, 1C, 1B, 23, 75, 6B, 72, 74) and the decoder state enum SHALL live in shared package kbd_pkg.
REQ-027 Synchronizer, frame shift, parity check and bit timeout SHALL be sub-module ps2_rx, with outputs byte[7:0], valid and err; keyboard_ctl SHALL instantiate ps2_rx and the decoder FSM.

Verification
REQ-028 Frame 1D -> key_w=1 within 3 cycles of the stop-bit edge; then F0,1D -> key_w=0; no other outputs change.
REQ-029 E0,6B -> key_left=1 and key_a stays 0; E0,F0,6B -> key_left=0.
REQ-030 1D frame with parity bit inverted -> one rx_err pulse, key_w stays 0; a following good 1C -> key_a=1.
REQ-031 E0, then silence for TIMEOUT_CYCLES+10, then 1C -> key_a=1 (not an extended code); FSM in IDLE before the 1C.
REQ-032 Hold W, D and up (1D; 23; E0 75); then AA -> all three go to 0 together in the same cycle.
REQ-033 rst after 5 bits of a frame, then a full 23 frame -> key_d=1 and no rx_err pulse.
